// File: rtl/rs_psel_pkg.sv
// Shared constants and helpers for the reservation-station grant selector.
// Default sizes plus slot extraction and one-hot decoding reused by the RS.
package rs_psel_pkg;

  localparam int DEF_REQS  = 3;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_PTR_W = $clog2(DEF_WIDTH);

  // Slot k field of a packed grant bus at default sizing.
  function automatic logic [DEF_WIDTH-1:0] gnt_slot(
    input logic [DEF_REQS*DEF_WIDTH-1:0] bus,
    input int                            k
  );
    return bus[k*DEF_WIDTH +: DEF_WIDTH];
  endfunction

  function automatic logic [DEF_PTR_W-1:0] onehot_to_idx(
    input logic [DEF_WIDTH-1:0] oh
  );
    logic [DEF_PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DEF_WIDTH; i++) begin
      if (oh[i]) idx = idx | DEF_PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rs_rr_scan.sv
// Combinational multi-grant scan: rotate requests to the start point, pick up
// to REQS first-set bits in cascade, and map each winner back to its entry.
module rs_rr_scan
  import rs_psel_pkg::*;
#(
  parameter  int REQS  = DEF_REQS,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int PTR_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]       req,
  input  logic [PTR_W-1:0]       base,
  output logic [REQS*WIDTH-1:0]  gnt_bus,
  output logic [REQS*PTR_W-1:0]  gnt_idx,
  output logic [REQS-1:0]        gnt_valid,
  output logic [PTR_W-1:0]       last_idx
);

  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   mask;
  logic               found;
  logic [PTR_W-1:0]   pos;
  logic [PTR_W:0]     sum;
  logic [PTR_W-1:0]   actual;

  always_comb begin
    gnt_bus   = '0;
    gnt_idx   = '0;
    gnt_valid = '0;
    last_idx  = '0;
    found     = 1'b0;
    pos       = '0;
    sum       = '0;
    actual    = '0;
    // rotated bit j corresponds to entry (j + base) mod WIDTH
    dbl  = {req, req} >> base;
    mask = dbl[WIDTH-1:0];
    for (int k = 0; k < REQS; k++) begin
      found = 1'b0;
      pos   = '0;
      for (int j = 0; j < WIDTH; j++) begin
        if (!found && mask[j]) begin
          found   = 1'b1;
          pos     = PTR_W'(j);
          mask[j] = 1'b0;
        end
      end
      sum = {1'b0, pos} + {1'b0, base};
      if (sum >= (PTR_W+1)'(WIDTH)) sum = sum - (PTR_W+1)'(WIDTH);
      actual = sum[PTR_W-1:0];
      if (found) begin
        gnt_bus[k*WIDTH +: WIDTH] = WIDTH'(1) << actual;
        gnt_idx[k*PTR_W +: PTR_W] = actual;
        gnt_valid[k]              = 1'b1;
        last_idx                  = actual;
      end
    end
  end

endmodule

// File: rtl/rs_rr_psel.sv
// Registered multi-grant selector with fixed or round-robin priority.
// Grants appear one cycle after the request vector they were chosen from.
module rs_rr_psel
  import rs_psel_pkg::*;
#(
  parameter  int REQS  = DEF_REQS,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int PTR_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(REQS+1)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   stall,
  input  logic                   rr_mode,
  input  logic [WIDTH-1:0]       req,
  output logic [REQS*WIDTH-1:0]  gnt_bus,
  output logic [REQS*PTR_W-1:0]  gnt_idx,
  output logic [REQS-1:0]        gnt_valid,
  output logic [CNT_W-1:0]       gnt_cnt,
  output logic [PTR_W-1:0]       ptr
);

  logic [REQS*WIDTH-1:0] nxt_bus;
  logic [REQS*PTR_W-1:0] nxt_idx;
  logic [REQS-1:0]       nxt_valid;
  logic [PTR_W-1:0]      last_idx;
  logic [CNT_W-1:0]      nxt_cnt;
  logic [PTR_W-1:0]      nxt_ptr;
  logic [PTR_W-1:0]      base;

  assign base = rr_mode ? ptr : '0;

  rs_rr_scan #(.REQS(REQS), .WIDTH(WIDTH)) u_scan (
    .req       (req),
    .base      (base),
    .gnt_bus   (nxt_bus),
    .gnt_idx   (nxt_idx),
    .gnt_valid (nxt_valid),
    .last_idx  (last_idx)
  );

  always_comb begin
    nxt_cnt = '0;
    for (int k = 0; k < REQS; k++) begin
      if (nxt_valid[k]) nxt_cnt = nxt_cnt + CNT_W'(1);
    end
    nxt_ptr = (last_idx == PTR_W'(WIDTH-1)) ? '0 : last_idx + PTR_W'(1);
  end

  // stall beats en; the pointer only advances in rr mode when something won
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_bus   <= '0;
      gnt_idx   <= '0;
      gnt_valid <= '0;
      gnt_cnt   <= '0;
      ptr       <= '0;
    end else if (stall) begin
      gnt_bus   <= gnt_bus;
      gnt_idx   <= gnt_idx;
      gnt_valid <= gnt_valid;
      gnt_cnt   <= gnt_cnt;
      ptr       <= ptr;
    end else if (!en) begin
      gnt_bus   <= '0;
      gnt_idx   <= '0;
      gnt_valid <= '0;
      gnt_cnt   <= '0;
    end else begin
      gnt_bus   <= nxt_bus;
      gnt_idx   <= nxt_idx;
      gnt_valid <= nxt_valid;
      gnt_cnt   <= nxt_cnt;
      if (rr_mode && nxt_valid[0]) ptr <= nxt_ptr;
    end
  end

endmodule

// File: tb/tb_rs_rr_psel.sv
// Directed bench for rs_rr_psel: reset, fixed and round-robin scans, wrap,
// stall/disable holds and asynchronous reset mid-cycle.
module tb_rs_rr_psel;
  import rs_psel_pkg::*;

  localparam int REQS  = DEF_REQS;
  localparam int WIDTH = DEF_WIDTH;
  localparam int PTR_W = DEF_PTR_W;
  localparam int CNT_W = $clog2(REQS+1);

  logic                  clock;
  logic                  reset_n;
  logic                  en;
  logic                  stall;
  logic                  rr_mode;
  logic [WIDTH-1:0]      req;
  logic [REQS*WIDTH-1:0] gnt_bus;
  logic [REQS*PTR_W-1:0] gnt_idx;
  logic [REQS-1:0]       gnt_valid;
  logic [CNT_W-1:0]      gnt_cnt;
  logic [PTR_W-1:0]      ptr;

  int n_cmp;
  int n_err;

  rs_rr_psel #(.REQS(REQS), .WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (en),
    .stall     (stall),
    .rr_mode   (rr_mode),
    .req       (req),
    .gnt_bus   (gnt_bus),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .gnt_cnt   (gnt_cnt),
    .ptr       (ptr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic [47:0] bus, input logic [11:0] idx,
                           input logic [2:0] vld, input logic [1:0] cnt, input logic [3:0] p);
    check({tag, ".bus"}, 64'(gnt_bus), 64'(bus));
    check({tag, ".idx"}, 64'(gnt_idx), 64'(idx));
    check({tag, ".valid"}, 64'(gnt_valid), 64'(vld));
    check({tag, ".cnt"}, 64'(gnt_cnt), 64'(cnt));
    check({tag, ".ptr"}, 64'(ptr), 64'(p));
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic [3:0] b;
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    en      = 1'b1;
    stall   = 1'b0;
    rr_mode = 1'b0;
    req     = 16'hffff;

    // 1: reset holds everything at zero
    step();
    step();
    check_all("reset", 48'h0, 12'h0, 3'b000, 2'd0, 4'd0);
    reset_n = 1'b1;

    // 2: fixed priority from entry 0, pointer untouched
    for (int c = 0; c < 4; c++) begin
      step();
      check_all($sformatf("fixed%0d", c), 48'h0004_0002_0001, 12'h210, 3'b111, 2'd3, 4'd0);
    end

    // 3: round-robin walk through all entries, sixth set wraps 15/0/1
    rr_mode = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      b = 4'(3 * c);
      check($sformatf("rr%0d.idx", c), 64'(gnt_idx), 64'({b + 4'd2, b + 4'd1, b}));
      check($sformatf("rr%0d.ptr", c), 64'(ptr), 64'(b + 4'd3));
    end
    step();
    check_all("rr_wrap", 48'h0002_0001_8000, 12'h10F, 3'b111, 2'd3, 4'd2);

    // 4: move pointer to 3, then two requests straddling the wrap
    req = 16'h0004;
    step();
    check_all("rr_single", 48'h0000_0000_0004, 12'h002, 3'b001, 2'd1, 4'd3);
    req = 16'h8001;
    step();
    check("pair.slot0", 64'(gnt_slot(gnt_bus, 0)), 64'h8000);
    check("pair.slot1", 64'(gnt_slot(gnt_bus, 1)), 64'h0001);
    check("pair.slot2", 64'(gnt_slot(gnt_bus, 2)), 64'h0000);
    check_all("pair", 48'h0000_0001_8000, 12'h00F, 3'b011, 2'd2, 4'd1);

    // 5: stall holds, en low clears, empty request clears
    req = 16'h00f0;
    step();
    check_all("pre_stall", 48'h0040_0020_0010, 12'h654, 3'b111, 2'd3, 4'd7);
    stall = 1'b1;
    step();
    check_all("stall0", 48'h0040_0020_0010, 12'h654, 3'b111, 2'd3, 4'd7);
    req = 16'h0f00;
    step();
    check_all("stall1", 48'h0040_0020_0010, 12'h654, 3'b111, 2'd3, 4'd7);
    stall = 1'b0;
    en    = 1'b0;
    step();
    check_all("disable", 48'h0, 12'h0, 3'b000, 2'd0, 4'd7);
    en  = 1'b1;
    req = 16'h0000;
    step();
    check_all("empty", 48'h0, 12'h0, 3'b000, 2'd0, 4'd7);

    // 6: reach ptr 9 with three grants, then reset between edges
    req = 16'h0020;
    step();
    check_all("to6", 48'h0000_0000_0020, 12'h005, 3'b001, 2'd1, 4'd6);
    req = 16'hffff;
    step();
    check_all("to9", 48'h0100_0080_0040, 12'h876, 3'b111, 2'd3, 4'd9);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 48'h0, 12'h0, 3'b000, 2'd0, 4'd0);
    stall = 1'b1;
    step();
    check_all("rst_stall", 48'h0, 12'h0, 3'b000, 2'd0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rs_rr_psel.md
Name: rs_rr_psel

Overview:
Registered multi-grant selector for reservation-station entry allocation and issue. Picks up to REQS requesting entries out of WIDTH per cycle. Supports two priority modes:
- fixed: scan from index 0, same ordering as the existing combinational selector;
- round-robin: a rotating start pointer prevents starvation of high-index entries.

Sits between the RS entry valid/ready vector and the dispatch/issue slots. Outputs are registered, giving one cycle of latency.

Parameters:
- REQS, 3, number of grant slots per cycle; 1 <= REQS <= WIDTH
- WIDTH, 16, number of request lines / RS entries; >= 2
- PTR_W, $clog2(WIDTH), pointer and index width (derived, not overridden)

Ports:
- clock, input, 1, system clock, rising edge
- reset_n, input, 1, asynchronous active-low reset
- en, input, 1, enable grant generation
- stall, input, 1, hold all outputs and the pointer; wins over en
- rr_mode, input, 1, 0 = fixed priority from index 0; 1 = round-robin from ptr
- req, input, WIDTH, request vector; bit i = entry i requests
- gnt_bus, output, REQS*WIDTH, one-hot grant per slot; slot k at [k*WIDTH +: WIDTH]
- gnt_idx, output, REQS*PTR_W, binary index of each slot's grant; slot k at [k*PTR_W +: PTR_W]
- gnt_valid, output, REQS, slot k holds a grant
- gnt_cnt, output, $clog2(REQS+1), number of valid slots
- ptr, output, PTR_W, current round-robin start pointer

Behaviour:
- Reset (reset_n low, async): gnt_bus, gnt_idx, gnt_valid, gnt_cnt and ptr all 0 immediately. They stay 0 until the first rising edge after deassertion.
- Scan order:
  - fixed mode: i = 0, 1, ..., WIDTH-1;
  - rr mode: i = ptr, ptr+1, ..., wrapping mod WIDTH, ending at ptr-1.
- Slot k receives the (k+1)-th set bit of req in scan order. No bit is granted twice.
- Slots beyond the number of set bits are 0, with gnt_valid[k] = 0 and gnt_idx = 0.
- Valid slots are always contiguous from slot 0. gnt_cnt = popcount(gnt_valid).
- Latency: selection is combinational from (req, ptr, rr_mode) and registered on the rising edge. Outputs reflect req from the previous cycle.
- Per rising edge, in priority order:
  - stall = 1: all registers hold, en ignored;
  - en = 0: grant registers load 0, ptr holds;
  - en = 1: grant registers load the new selection. In rr mode with >= 1 grant, ptr loads (index of last valid slot + 1) mod WIDTH. Otherwise ptr holds.
- Fixed mode never modifies ptr. Switching rr_mode takes effect on the next selection with no pointer reset.
- req all zero with en = 1: all grant outputs 0 next cycle, ptr holds.
- Wrap-around: last grant at WIDTH-1 sets ptr to 0. Grants may straddle the wrap, e.g. indices 15, 0, 1.
- Reset asserted mid-operation overrides stall and en at once. There is no pending state to flush.
- No X propagation: req bits are treated as given; the bench drives no X after reset.

Decomposition:
- Shared package rs_psel_pkg holds:
  - default REQS/WIDTH constants;
  - a function returning the slot-k field of a packed gnt_bus;
  - an onehot-to-index function reused by the RS.
- One sub-module, rs_rr_scan (combinational):
  - rotates req by ptr (or by 0 in fixed mode);
  - runs REQS cascaded find-first-set stages, masking each winner;
  - rotates grants back;
  - produces the next gnt_bus, gnt_idx, gnt_valid and last-granted index.
- rs_rr_psel wraps it with the output registers and the pointer register.

Test Plan:
1. reset_n low for 2 cycles, req = 16'hffff, en = 1 -> all outputs 0, ptr = 0. Release -> first grants appear one edge after the first sampled rising edge.
2. rr_mode = 0, en = 1, req = 16'hffff -> next cycle slots = 16'h0001/16'h0002/16'h0004, gnt_idx = 0/1/2, gnt_valid = 3'b111, gnt_cnt = 3. ptr stays 0 over 4 cycles.
3. rr_mode = 1, req = 16'hffff held 6 cycles -> ptr sequence 3, 6, 9, 12, 15, 2. The sixth grant set has gnt_idx = 15/0/1 (wrap).
4. rr_mode = 1, ptr = 3, req = 16'h8001 -> slot0 = 16'h8000, slot1 = 16'h0001, slot2 = 0, gnt_valid = 3'b011, gnt_cnt = 2, ptr -> 1.
5. Hold and disable:
   - stall = 1 while req changes 16'h00f0 -> 16'h0f00: outputs and ptr unchanged for each stalled cycle.
   - stall = 0, en = 0: outputs 0 next cycle, ptr held.
   - req = 0, en = 1: outputs 0, ptr held.
6. Mid-cycle reset: drop reset_n between edges while gnt_valid = 3'b111 and ptr = 9 -> all outputs 0 and ptr = 0 before the next edge. Hold reset_n low with stall = 1 -> outputs remain 0.
